// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA engine: halts the CPU and copies one RAM page into PPU OAMDATA.
module oam_dma_ctrl #(
    parameter int          NUM_BYTES = 256,
    parameter logic [2:0]  OAM_REG   = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data_in,
    output logic        ppu_reg_cs,
    output logic [2:0]  ppu_reg_addr,
    output logic        vram_WE,
    output logic [7:0]  cpu_data_out,
    output logic        rdy,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;

    localparam logic [8:0] LAST = 9'(NUM_BYTES - 1);

    state_t     state;
    logic [7:0] page;
    logic [8:0] count;
    logic       cyc_odd;
    logic       odd_start;

    // Strobes are registered alongside the state they belong to, so they
    // never depend combinationally on dma_start or other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            page         <= 8'h00;
            count        <= 9'd0;
            cyc_odd      <= 1'b0;
            odd_start    <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_rd       <= 1'b0;
            ppu_reg_cs   <= 1'b0;
            ppu_reg_addr <= 3'd0;
            vram_WE      <= 1'b0;
            rdy          <= 1'b1;
            dma_busy     <= 1'b0;
            dma_done     <= 1'b0;
        end else begin
            cyc_odd      <= ~cyc_odd;
            mem_addr     <= 16'h0000;
            mem_rd       <= 1'b0;
            ppu_reg_cs   <= 1'b0;
            ppu_reg_addr <= 3'd0;
            vram_WE      <= 1'b0;
            dma_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_start) begin
                        page      <= dma_page;
                        count     <= 9'd0;
                        odd_start <= cyc_odd;
                        rdy       <= 1'b0;
                        dma_busy  <= 1'b1;
                        state     <= HALT;
                    end
                end
                HALT: begin
                    if (odd_start) begin
                        state <= ALIGN;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, count[7:0]};
                        state    <= READ;
                    end
                end
                ALIGN: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= {page, count[7:0]};
                    state    <= READ;
                end
                READ: begin
                    ppu_reg_cs   <= 1'b1;
                    vram_WE      <= 1'b1;
                    ppu_reg_addr <= OAM_REG;
                    state        <= WRITE;
                end
                WRITE: begin
                    count <= count + 9'd1;
                    if (count == LAST) begin
                        dma_done <= 1'b1;
                        rdy      <= 1'b1;
                        dma_busy <= 1'b0;
                        state    <= DONE;
                    end else begin
                        // Low byte wraps inside the page; the page byte is never touched.
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, count[7:0] + 8'd1};
                        state    <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    rdy      <= 1'b1;
                    dma_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // RAM data arrives the cycle after mem_rd, which is exactly the WRITE cycle.
    assign cpu_data_out = vram_WE ? mem_data_in : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - directed bench for oam_dma_ctrl (full-page and 4-byte instances).
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        par = 1'b0;

    logic        a_start = 1'b0, b_start = 1'b0;
    logic [7:0]  a_page = 8'h00, b_page = 8'h00;
    logic [15:0] a_addr, b_addr;
    logic        a_rd, b_rd, a_cs, b_cs, a_we, b_we;
    logic        a_rdy, b_rdy, a_busy, b_busy, a_done, b_done;
    logic [2:0]  a_ra, b_ra;
    logic [7:0]  a_dout, b_dout;
    logic [7:0]  a_din = 8'h00, b_din = 8'h00;

    logic [7:0]  a_exp_page = 8'h00, b_exp_page = 8'h00;
    int a_wr, a_rdc, a_low, a_quiet, a_dn, a_aerr, a_derr;
    int b_wr, b_rdc, b_low, b_quiet, b_dn, b_aerr, b_derr;
    int proto_err = 0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    oam_dma_ctrl u_a (
        .clk(clk), .reset(reset), .dma_start(a_start), .dma_page(a_page),
        .mem_addr(a_addr), .mem_rd(a_rd), .mem_data_in(a_din),
        .ppu_reg_cs(a_cs), .ppu_reg_addr(a_ra), .vram_WE(a_we),
        .cpu_data_out(a_dout), .rdy(a_rdy), .dma_busy(a_busy), .dma_done(a_done)
    );

    oam_dma_ctrl #(.NUM_BYTES(4), .OAM_REG(3'd4)) u_b (
        .clk(clk), .reset(reset), .dma_start(b_start), .dma_page(b_page),
        .mem_addr(b_addr), .mem_rd(b_rd), .mem_data_in(b_din),
        .ppu_reg_cs(b_cs), .ppu_reg_addr(b_ra), .vram_WE(b_we),
        .cpu_data_out(b_dout), .rdy(b_rdy), .dma_busy(b_busy), .dma_done(b_done)
    );

    // Page $02 holds i ^ A5; other pages are distinct so a wrong page shows up as bad data.
    function automatic logic [7:0] ram_byte(input logic [15:0] addr);
        return addr[7:0] ^ 8'hA5 ^ addr[15:8] ^ 8'h02;
    endfunction

    always @(posedge clk) begin
        if (a_rd) a_din <= ram_byte(a_addr);
        if (b_rd) b_din <= ram_byte(b_addr);
        par <= reset ? 1'b0 : ~par;
    end

    always @(negedge clk) begin
        if ((a_we && !(a_cs && a_ra == 3'd4)) || (a_rd && a_we) || (a_rdy && (a_rd || a_we)) ||
            (!a_we && a_dout != 8'h00))
            proto_err++;
        if ((b_we && !(b_cs && b_ra == 3'd4)) || (b_rd && b_we) || (b_rdy && (b_rd || b_we)) ||
            (!b_we && b_dout != 8'h00))
            proto_err++;
        if (clr) begin
            a_wr = 0; a_rdc = 0; a_low = 0; a_quiet = 0; a_dn = 0; a_aerr = 0; a_derr = 0;
            b_wr = 0; b_rdc = 0; b_low = 0; b_quiet = 0; b_dn = 0; b_aerr = 0; b_derr = 0;
        end else begin
            if (a_rd) begin
                if (a_addr != {a_exp_page, 8'(a_rdc)}) a_aerr++;
                a_rdc++;
            end
            if (a_we) begin
                if (a_dout != ram_byte({a_exp_page, 8'(a_wr)})) a_derr++;
                a_wr++;
            end
            if (!a_rdy) a_low++;
            if (!a_rdy && !a_rd && !a_we) a_quiet++;
            if (a_done) a_dn++;
            if (b_rd) begin
                if (b_addr != {b_exp_page, 8'(b_rdc)}) b_aerr++;
                b_rdc++;
            end
            if (b_we) begin
                if (b_dout != ram_byte({b_exp_page, 8'(b_wr)})) b_derr++;
                b_wr++;
            end
            if (!b_rdy) b_low++;
            if (!b_rdy && !b_rd && !b_we) b_quiet++;
            if (b_done) b_dn++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    // Launch so that the accepting edge samples cyc_odd == want_odd.
    task automatic launch(input bit sel_b, input logic [7:0] pg, input bit want_odd);
        @(posedge clk); #1;
        if (par != want_odd) begin
            @(posedge clk); #1;
        end
        if (sel_b) begin b_page = pg; b_start = 1'b1; end
        else       begin a_page = pg; a_start = 1'b1; end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input string tag);
        int n = 0;
        while (!(sel_b ? b_done : a_done) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, int'(n < 3000), 1);
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    task automatic check_full(input string tag, input int low, input int quiet);
        chk({tag, "_writes"}, a_wr, 256);
        chk({tag, "_reads"}, a_rdc, 256);
        chk({tag, "_addr_err"}, a_aerr, 0);
        chk({tag, "_data_err"}, a_derr, 0);
        chk({tag, "_rdy_low"}, a_low, low);
        chk({tag, "_quiet"}, a_quiet, quiet);
        chk({tag, "_done"}, a_dn, 1);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", int'(a_rdy), 1);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_rd", int'(a_rd), 0);
        chk("rst_we", int'(a_we), 0);
        chk("rst_cs", int'(a_cs), 0);
        chk("rst_addr", int'(a_addr), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_dout", int'(a_dout), 0);
        reset = 1'b0;
        clear_counts();

        // Basic, even start
        a_exp_page = 8'h02;
        launch(1'b0, 8'h02, 1'b0);
        wait_done(1'b0, "basic_timeout");
        check_full("basic", 513, 1);
        chk("basic_idle_rdy", int'(a_rdy), 1);
        chk("basic_idle_busy", int'(a_busy), 0);

        // Odd start
        clear_counts();
        launch(1'b0, 8'h02, 1'b1);
        wait_done(1'b0, "odd_timeout");
        check_full("odd", 514, 2);

        // Busy ignore
        clear_counts();
        a_exp_page = 8'h03;
        launch(1'b0, 8'h03, 1'b0);
        n = 0;
        while (a_wr < 10 && n < 200) begin @(negedge clk); #1; n++; end
        chk("busy_reach10", int'(n < 200), 1);
        a_page = 8'h07;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_done(1'b0, "busy_timeout");
        repeat (20) @(negedge clk);
        #1;
        check_full("busy", 513, 1);
        chk("busy_no_second", int'(a_rdy), 1);

        // Reset mid-op
        clear_counts();
        a_exp_page = 8'h03;
        launch(1'b0, 8'h03, 1'b0);
        n = 0;
        while (a_wr < 100 && n < 400) begin @(negedge clk); #1; n++; end
        chk("rst_mid_reach100", int'(n < 400), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_rdy", int'(a_rdy), 1);
        chk("rst_mid_we", int'(a_we), 0);
        chk("rst_mid_rd", int'(a_rd), 0);
        chk("rst_mid_busy", int'(a_busy), 0);
        chk("rst_mid_done", int'(a_done), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_mid_no_done", a_dn, 0);
        clear_counts();
        a_exp_page = 8'h04;
        launch(1'b0, 8'h04, 1'b0);
        wait_done(1'b0, "after_rst_timeout");
        check_full("after_rst", 513, 1);

        // Four-byte instance, page $FF, both parities
        clear_counts();
        b_exp_page = 8'hFF;
        launch(1'b1, 8'hFF, 1'b0);
        wait_done(1'b1, "p4_even_timeout");
        chk("p4_even_writes", b_wr, 4);
        chk("p4_even_reads", b_rdc, 4);
        chk("p4_even_addr_err", b_aerr, 0);
        chk("p4_even_data_err", b_derr, 0);
        chk("p4_even_rdy_low", b_low, 9);
        chk("p4_even_done", b_dn, 1);
        chk("p4_even_idle_rdy", int'(b_rdy), 1);
        chk("p4_even_idle_busy", int'(b_busy), 0);
        clear_counts();
        launch(1'b1, 8'hFF, 1'b1);
        wait_done(1'b1, "p4_odd_timeout");
        chk("p4_odd_writes", b_wr, 4);
        chk("p4_odd_addr_err", b_aerr, 0);
        chk("p4_odd_data_err", b_derr, 0);
        chk("p4_odd_rdy_low", b_low, 10);
        chk("p4_odd_quiet", b_quiet, 2);
        chk("p4_odd_done", b_dn, 1);

        chk("protocol", proto_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
